// File: rtl/ram_1r1w_stream_if.sv
// Write strobe plus valid/ready read request/response bundle for ram_1r1w_stream.
// The master side is the client; the slave side is the RAM.
interface ram_1r1w_stream_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int BYTE_W = 8
);
    localparam int NUM_BE = DATA_W / BYTE_W;

    logic              wr_val;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NUM_BE-1:0] wr_be;
    logic              rd_req_val;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_rdy;
    logic              rd_resp_val;
    logic [DATA_W-1:0] rd_resp_data;
    logic              rd_resp_rdy;

    modport master (
        output wr_val, wr_addr, wr_data, wr_be,
        output rd_req_val, rd_req_addr, rd_resp_rdy,
        input  rd_req_rdy, rd_resp_val, rd_resp_data
    );

    modport slave (
        input  wr_val, wr_addr, wr_data, wr_be,
        input  rd_req_val, rd_req_addr, rd_resp_rdy,
        output rd_req_rdy, rd_resp_val, rd_resp_data
    );
endinterface

// File: rtl/ram_1r1w_stream.sv
// 1R1W block RAM with byte-lane writes, a backpressured read stream and a
// selectable read-during-write policy; responses drain through a small FIFO.
module ram_1r1w_stream #(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 256,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int BYTE_W   = 8,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input logic              clk,
    input logic              rst,
    ram_1r1w_stream_if.slave bus
);
    localparam int NUM_BE  = DATA_W / BYTE_W;
    localparam int LAT     = 1 + OUT_REG;
    localparam int MAX_OUT = LAT + 1;
    localparam int PTR_W   = $clog2(MAX_OUT);
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    localparam logic [ADDR_W:0]  DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUT);

    function automatic logic [DATA_W-1:0] lane_mask(input logic [NUM_BE-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_BE; i++) m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_data,
                                                     input logic [DATA_W-1:0] new_data,
                                                     input logic [DATA_W-1:0] mask);
        return (old_data & ~mask) | (new_data & mask);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic [CNT_W-1:0]  cnt;
    logic              req_rdy;
    logic              acc;
    logic              wr_en;
    logic              wr_in_range;
    logic              rd_in_range;
    logic [DATA_W-1:0] wr_mask;

    // Request side: rdy depends only on the outstanding count, never on rd_resp_rdy.
    assign wr_in_range = {1'b0, bus.wr_addr} < DEPTH_C;
    assign rd_in_range = {1'b0, bus.rd_req_addr} < DEPTH_C;
    assign req_rdy     = rst && (cnt < CNT_MAX);
    assign acc         = bus.rd_req_val && req_rdy;
    assign wr_en       = rst && bus.wr_val && wr_in_range;
    assign wr_mask     = lane_mask(bus.wr_be);

    assign bus.rd_req_rdy = req_rdy;

    // ---- stage p0: array read register (old-data read-during-write) ----
    logic [DATA_W-1:0] mem_q_p0;
    logic [DATA_W-1:0] wr_data_p0;
    logic [DATA_W-1:0] wr_mask_p0;
    logic              rdw_hit_p0;
    logic              oor_p0;
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BE; i++) begin
            if (wr_en && bus.wr_be[i])
                mem[bus.wr_addr][i*BYTE_W +: BYTE_W] <= bus.wr_data[i*BYTE_W +: BYTE_W];
        end
        if (acc) mem_q_p0 <= mem[bus.rd_req_addr];
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            rdw_hit_p0 <= wr_en && (bus.wr_addr == bus.rd_req_addr);
            wr_data_p0 <= bus.wr_data;
            wr_mask_p0 <= wr_mask;
            oor_p0     <= !rd_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= acc;
    end

    // Merge is applied after the array register so the BRAM stays a plain old-data read.
    always_comb begin
        data_p0 = mem_q_p0;
        if (RDW_MODE != 0 && rdw_hit_p0) data_p0 = byte_merge(mem_q_p0, wr_data_p0, wr_mask_p0);
        if (oor_p0) data_p0 = '0;
    end

    // ---- stage p1: optional output register ----
    logic [DATA_W-1:0] out_data;
    logic              out_vld;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] data_p1;
            logic              vld_p1;

            always_ff @(posedge clk) begin
                if (vld_p0) data_p1 <= data_p0;
            end

            always_ff @(posedge clk) begin
                if (!rst) vld_p1 <= 1'b0;
                else      vld_p1 <= vld_p0;
            end

            assign out_data = data_p1;
            assign out_vld  = vld_p1;
        end else begin : g_no_out_reg
            assign out_data = data_p0;
            assign out_vld  = vld_p0;
        end
    endgenerate

    // ---- response FIFO with empty-bypass so data is visible LAT cycles after accept ----
    logic [DATA_W-1:0] fifo_mem [MAX_OUT];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  fcnt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              resp_val;
    logic              pop;
    logic              pop_fifo;
    logic              push;

    assign fifo_empty = (fcnt == '0);
    assign fifo_full  = (fcnt == CNT_MAX);
    assign resp_val   = rst && (!fifo_empty || out_vld);
    assign pop        = resp_val && bus.rd_resp_rdy;
    assign pop_fifo   = pop && !fifo_empty;
    assign push       = out_vld && !(fifo_empty && pop);

    assign bus.rd_resp_val  = resp_val;
    assign bus.rd_resp_data = fifo_empty ? out_data : fifo_mem[rptr];

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= out_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            fcnt <= '0;
            wptr <= '0;
            rptr <= '0;
        end else begin
            cnt  <= cnt + CNT_W'(acc) - CNT_W'(pop);
            fcnt <= fcnt + CNT_W'(push) - CNT_W'(pop_fifo);
            if (push)     wptr <= ptr_inc(wptr);
            if (pop_fifo) rptr <= ptr_inc(rptr);
        end
    end

`ifndef SYNTHESIS
    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst) cnt <= CNT_MAX);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && fifo_full));
`endif

endmodule

// File: tb/tb_ram_1r1w_stream.sv
// Directed bench driving two RAM configurations with identical stimulus:
// dut0 = old-data RDW, no output register; dut1 = merged RDW, output register, DEPTH=200.
module tb_ram_1r1w_stream;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int BYTE_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              wr_val;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        wr_be;
    logic              rd_req_val;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_resp_rdy;

    ram_1r1w_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) bus0 ();
    ram_1r1w_stream_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W)) bus1 ();

    assign bus0.wr_val = wr_val;           assign bus1.wr_val = wr_val;
    assign bus0.wr_addr = wr_addr;         assign bus1.wr_addr = wr_addr;
    assign bus0.wr_data = wr_data;         assign bus1.wr_data = wr_data;
    assign bus0.wr_be = wr_be;             assign bus1.wr_be = wr_be;
    assign bus0.rd_req_val = rd_req_val;   assign bus1.rd_req_val = rd_req_val;
    assign bus0.rd_req_addr = rd_req_addr; assign bus1.rd_req_addr = rd_req_addr;
    assign bus0.rd_resp_rdy = rd_resp_rdy; assign bus1.rd_resp_rdy = rd_resp_rdy;

    ram_1r1w_stream #(.DATA_W(DATA_W), .DEPTH(256), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W),
                      .RDW_MODE(0), .OUT_REG(0))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));

    ram_1r1w_stream #(.DATA_W(DATA_W), .DEPTH(200), .ADDR_W(ADDR_W), .BYTE_W(BYTE_W),
                      .RDW_MODE(1), .OUT_REG(1))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pat(input logic [7:0] a);
        return {8{a}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] rq0[$];
    logic [63:0] rq1[$];
    int          rc0[$];
    int          rc1[$];

    always @(negedge clk) begin
        if (bus0.rd_resp_val && bus0.rd_resp_rdy) begin
            rq0.push_back(bus0.rd_resp_data);
            rc0.push_back(cyc);
        end
        if (bus1.rd_resp_val && bus1.rd_resp_rdy) begin
            rq1.push_back(bus1.rd_resp_data);
            rc1.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        rq0.delete(); rq1.delete(); rc0.delete(); rc1.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int b0;
        int b1;
        logic [63:0] e0 [4];
        logic [63:0] e1 [4];

        wr_val = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_req_val = 1'b1; rd_req_addr = '0; rd_resp_rdy = 1'b1;

        // Reset held for four cycles with a pending request
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_req_rdy0", bus0.rd_req_rdy, 0);
            check("rst_req_rdy1", bus1.rd_req_rdy, 0);
            check("rst_resp_val0", bus0.rd_resp_val, 0);
            check("rst_resp_val1", bus1.rd_resp_val, 0);
        end
        step(); rst = 1'b1; rd_req_val = 1'b0;
        @(negedge clk);
        check("rel_req_rdy0", bus0.rd_req_rdy, 1);
        check("rel_req_rdy1", bus1.rd_req_rdy, 1);

        // Fill every address with a known pattern
        for (int a = 0; a < 256; a++) begin
            step(); wr_val = 1'b1; wr_addr = 8'(a); wr_data = pat(8'(a)); wr_be = 8'hFF;
        end
        step(); wr_val = 1'b0;

        // Streaming reads, one per cycle
        clear_q(); b0 = 0; b1 = 0; c0 = 0;
        for (int a = 0; a < 256; a++) begin
            step(); rd_req_val = 1'b1; rd_req_addr = 8'(a);
            if (a == 0) c0 = cyc;
            @(negedge clk);
            if (!bus0.rd_req_rdy) b0++;
            if (!bus1.rd_req_rdy) b1++;
        end
        step(); rd_req_val = 1'b0;
        repeat (5) step();
        check("stream_bubbles0", b0, 0);
        check("stream_bubbles1", b1, 0);
        check("stream_count0", rq0.size(), 256);
        check("stream_count1", rq1.size(), 256);
        for (int k = 0; k < 256; k++) begin
            if (k < rq0.size()) begin
                check("stream_data0", rq0[k], pat(8'(k)));
                check("stream_lat0", rc0[k] - c0 - k, 1);
            end
            if (k < rq1.size()) begin
                check("stream_data1", rq1[k], (k < 200) ? pat(8'(k)) : 64'h0);
                check("stream_lat1", rc1[k] - c0 - k, 2);
            end
        end

        // Byte enables: full write, low-half write, then an all-lanes-off write
        clear_q();
        step(); wr_val = 1'b1; wr_addr = 8'd5; wr_data = {8{8'h11}}; wr_be = 8'hFF;
        step(); wr_data = {8{8'hAA}}; wr_be = 8'h0F;
        step(); wr_data = {8{8'hFF}}; wr_be = 8'h00;
        step(); wr_val = 1'b0; rd_req_val = 1'b1; rd_req_addr = 8'd5;
        step(); rd_req_val = 1'b0;
        repeat (4) step();
        check("be_count0", rq0.size(), 1);
        check("be_count1", rq1.size(), 1);
        if (rq0.size() > 0) check("be_data0", rq0[0], 64'h11111111_AAAAAAAA);
        if (rq1.size() > 0) check("be_data1", rq1[0], 64'h11111111_AAAAAAAA);

        // Backpressure: six requests offered with the consumer stalled
        clear_q();
        step(); rd_resp_rdy = 1'b0; rd_req_val = 1'b1; rd_req_addr = 8'd20;
        for (int i = 1; i < 6; i++) begin
            step(); rd_req_addr = 8'(20 + i);
        end
        step(); rd_req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req_rdy0", bus0.rd_req_rdy, 0);
            check("bp_req_rdy1", bus1.rd_req_rdy, 0);
            check("bp_resp_val0", bus0.rd_resp_val, 1);
            check("bp_resp_val1", bus1.rd_resp_val, 1);
            check("bp_hold0", bus0.rd_resp_data, pat(8'd20));
            check("bp_hold1", bus1.rd_resp_data, pat(8'd20));
            step();
        end
        rd_resp_rdy = 1'b1;
        repeat (6) step();
        check("bp_count0", rq0.size(), 2);
        check("bp_count1", rq1.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (k < rq0.size()) check("bp_data0", rq0[k], pat(8'(20 + k)));
            if (k < rq1.size()) check("bp_data1", rq1[k], pat(8'(20 + k)));
        end
        @(negedge clk);
        check("bp_rdy_back0", bus0.rd_req_rdy, 1);
        check("bp_rdy_back1", bus1.rd_req_rdy, 1);

        // Read-during-write, late writes after the array read, back-to-back writes
        clear_q();
        step(); wr_val = 1'b1; wr_addr = 8'd9; wr_data = 64'hBEEF; wr_be = 8'hFF;
                rd_req_val = 1'b1; rd_req_addr = 8'd9;
        step(); wr_data = 64'h12345678_9ABCDEF0; wr_be = 8'h0F;
        step(); wr_val = 1'b0;
        step(); rd_req_val = 1'b0; wr_val = 1'b1; wr_data = 64'hDEAD; wr_be = 8'hFF;
        step(); wr_data = 64'hF00D;
        step(); wr_val = 1'b0; rd_req_val = 1'b1;
        step(); rd_req_val = 1'b0;
        repeat (5) step();
        e0[0] = pat(8'd9); e0[1] = 64'hBEEF;                e0[2] = 64'h9ABCDEF0; e0[3] = 64'hF00D;
        e1[0] = 64'hBEEF;  e1[1] = 64'h00000000_9ABCDEF0;   e1[2] = 64'h9ABCDEF0; e1[3] = 64'hF00D;
        check("rdw_count0", rq0.size(), 4);
        check("rdw_count1", rq1.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < rq0.size()) check("rdw_data0", rq0[k], e0[k]);
            if (k < rq1.size()) check("rdw_data1", rq1[k], e1[k]);
        end

        // Reset while two reads are outstanding and stalled
        clear_q();
        step(); rd_resp_rdy = 1'b0; rd_req_val = 1'b1; rd_req_addr = 8'd40;
        step(); rd_req_addr = 8'd41;
        step(); rd_req_val = 1'b0;
        step(); rst = 1'b0;
        @(negedge clk);
        check("mid_rst_rdy0", bus0.rd_req_rdy, 0);
        check("mid_rst_rdy1", bus1.rd_req_rdy, 0);
        check("mid_rst_val0", bus0.rd_resp_val, 0);
        check("mid_rst_val1", bus1.rd_resp_val, 0);
        step(); rst = 1'b1;
        @(negedge clk);
        check("post_rst_val0", bus0.rd_resp_val, 0);
        check("post_rst_val1", bus1.rd_resp_val, 0);
        check("post_rst_rdy0", bus0.rd_req_rdy, 1);
        check("post_rst_rdy1", bus1.rd_req_rdy, 1);
        repeat (3) step();
        rd_resp_rdy = 1'b1;
        repeat (4) step();
        check("dropped_count0", rq0.size(), 0);
        check("dropped_count1", rq1.size(), 0);
        step(); rd_req_val = 1'b1; rd_req_addr = 8'd42;
        step(); rd_req_val = 1'b0;
        repeat (5) step();
        check("after_rst_count0", rq0.size(), 1);
        check("after_rst_count1", rq1.size(), 1);
        if (rq0.size() > 0) check("after_rst_data0", rq0[0], pat(8'd42));
        if (rq1.size() > 0) check("after_rst_data1", rq1[0], pat(8'd42));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
